// File: rtl/conv_pkg.sv
// Shared CONV_256PE constants and the OFM drain state encoding.
// Also used by the PE-array feeder so both ends agree on lane and tile geometry.
package conv_pkg;

   localparam int NUM_OF_PE = 256;
   localparam int DATA_W    = 8;
   localparam int NUM_TILES = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } drain_state_e;

endpackage

// File: rtl/ofm_tile_drain.sv
// Latches a full PE-array OFM vector on capture and streams it out one byte per handshake.
// First byte the cycle after capture, 1 byte/cycle; out_valid holds with stable data under out_ready stalls.
module ofm_tile_drain #(
   parameter int NUM_OF_PE   = conv_pkg::NUM_OF_PE,
   parameter int DATA_W      = conv_pkg::DATA_W,
   parameter int NUM_TILES   = conv_pkg::NUM_TILES,
   parameter int ADDR_W      = $clog2(NUM_OF_PE * NUM_TILES),
   localparam int TILE_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic [NUM_OF_PE*DATA_W-1:0] OFM,
   input  logic                        ofm_capture,
   output logic                        capture_ready,
   output logic [DATA_W-1:0]           out_data,
   output logic [ADDR_W-1:0]           out_addr,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic [TILE_W-1:0]           tile_idx,
   output logic                        overflow,
   output logic                        all_done
);

   import conv_pkg::*;

   localparam int BYTE_W = (NUM_OF_PE > 1) ? $clog2(NUM_OF_PE) : 1;

   drain_state_e                  state_q, state_d;
   logic [NUM_OF_PE*DATA_W-1:0]   buf_q;
   logic [BYTE_W-1:0]             byte_idx_q, byte_idx_d;
   logic [TILE_W-1:0]             tile_idx_q, tile_idx_d;
   logic                          overflow_q, overflow_d;
   logic                          load_buf;
   logic                          last_byte;
   logic                          last_tile;

   assign last_byte = (byte_idx_q == BYTE_W'(NUM_OF_PE - 1));
   assign last_tile = (tile_idx_q == TILE_W'(NUM_TILES - 1));

   // A new tile may land on the final handshake of a non-final tile, avoiding an idle bubble.
   assign capture_ready = (state_q == IDLE) ||
                          ((state_q == DRAIN) && last_byte && out_ready && !last_tile);

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      tile_idx_d = tile_idx_q;
      overflow_d = overflow_q;
      load_buf   = 1'b0;

      if (start) begin
         state_d    = IDLE;
         byte_idx_d = '0;
         tile_idx_d = '0;
         overflow_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ofm_capture) begin
                  load_buf   = 1'b1;
                  byte_idx_d = '0;
                  state_d    = DRAIN;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (!last_byte) begin
                     byte_idx_d = byte_idx_q + BYTE_W'(1);
                  end else if (!last_tile) begin
                     tile_idx_d = tile_idx_q + TILE_W'(1);
                     byte_idx_d = '0;
                     if (ofm_capture) begin
                        load_buf = 1'b1;
                        state_d  = DRAIN;
                     end else begin
                        state_d  = IDLE;
                     end
                  end else begin
                     byte_idx_d = '0;
                     state_d    = DONE;
                  end
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         if (ofm_capture && !capture_ready) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         byte_idx_q <= '0;
         tile_idx_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         tile_idx_q <= tile_idx_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_q <= '0;
      end else if (load_buf) begin
         buf_q <= OFM;
      end
   end

   assign out_valid = (state_q == DRAIN);
   assign out_last  = (state_q == DRAIN) && last_byte;
   assign out_data  = buf_q[byte_idx_q*DATA_W +: DATA_W];
   assign out_addr  = ADDR_W'(tile_idx_q) * ADDR_W'(NUM_OF_PE) + ADDR_W'(byte_idx_q);
   assign tile_idx  = tile_idx_q;
   assign overflow  = overflow_q;
   assign all_done  = (state_q == DONE);

endmodule

// File: tb/tb_ofm_tile_drain.sv
// Scoreboard bench for ofm_tile_drain: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_ofm_tile_drain;
   import conv_pkg::*;

   localparam int AW = $clog2(NUM_OF_PE * NUM_TILES);
   localparam int TW = $clog2(NUM_TILES);
   localparam int VW = NUM_OF_PE * DATA_W;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          ofm_capture = 1'b0;
   logic          out_ready = 1'b0;
   logic [VW-1:0] OFM = '0;
   logic          capture_ready, out_valid, out_last, overflow, all_done;
   logic [DATA_W-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic [TW-1:0] tile_idx;

   always #5 clk = ~clk;

   ofm_tile_drain dut (
      .clk(clk), .reset_n(reset_n), .start(start), .OFM(OFM),
      .ofm_capture(ofm_capture), .capture_ready(capture_ready),
      .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .tile_idx(tile_idx),
      .overflow(overflow), .all_done(all_done)
   );

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic [AW-1:0]     a;
      logic              l;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Monitor: every accepted byte must match the queue head; stalled bytes must already show it.
   initial forever begin
      @(negedge clk);
      if (out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_byte: got addr %0d data %0h, expected no output", out_addr, out_data);
         end else if (out_ready) begin
            exp_t e;
            e = sb.pop_front();
            check("byte_data", 32'(out_data), 32'(e.d));
            check("byte_addr", 32'(out_addr), 32'(e.a));
            check("byte_last", 32'(out_last), 32'(e.l));
         end else begin
            check("stall_data", 32'(out_data), 32'(sb[0].d));
            check("stall_addr", 32'(out_addr), 32'(sb[0].a));
            check("stall_last", 32'(out_last), 32'(sb[0].l));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [VW-1:0] mk(input int kind, input int t);
      logic [VW-1:0] v;
      v = '0;
      for (int m = 0; m < NUM_OF_PE; m++) begin
         case (kind)
            0:       v[m*DATA_W +: DATA_W] = DATA_W'(m);
            1:       v[m*DATA_W +: DATA_W] = DATA_W'(t * 16 + (m % 16));
            2:       v[m*DATA_W +: DATA_W] = DATA_W'(m ^ 8'h5A);
            default: v[m*DATA_W +: DATA_W] = DATA_W'(255 - m);
         endcase
      end
      return v;
   endfunction

   task automatic push_tile(input logic [VW-1:0] v, input int t);
      for (int m = 0; m < NUM_OF_PE; m++)
         sb.push_back({v[m*DATA_W +: DATA_W], AW'(t * NUM_OF_PE + m), (m == NUM_OF_PE - 1)});
   endtask

   task automatic capture(input logic [VW-1:0] v, input int t);
      OFM = v;
      ofm_capture = 1'b1;
      push_tile(v, t);
      tick();
      ofm_capture = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_drain(input string name, input bit toggle, output int cyc);
      cyc = 0;
      while (sb.size() != 0 && cyc < 4000) begin
         if (toggle) out_ready = (cyc % 2 == 0);
         tick();
         cyc++;
      end
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL %s_timeout: got %0d bytes outstanding, expected 0", name, sb.size());
         sb.delete();
      end
      out_ready = 1'b1;
   endtask

   task automatic wait_addr(input string name, input int addr);
      int n;
      n = 0;
      while (out_addr != AW'(addr) && n < 600) begin
         tick();
         n++;
      end
      check(name, 32'(out_addr), addr);
   endtask

   initial begin
      int cyc;
      int n;

      // Reset values
      repeat (3) tick();
      check("rst_valid", 32'(out_valid), 0);
      check("rst_last", 32'(out_last), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_all_done", 32'(all_done), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_addr", 32'(out_addr), 0);
      check("rst_tile_idx", 32'(tile_idx), 0);
      check("rst_cap_ready", 32'(capture_ready), 1);
      reset_n = 1'b1;
      tick();

      // Single tile, ready held high, one-cycle latency
      out_ready = 1'b1;
      capture(mk(0, 0), 0);
      check("lat_valid", 32'(out_valid), 1);
      check("lat_addr", 32'(out_addr), 0);
      wait_drain("t1", 1'b0, cyc);
      check("t1_idle_valid", 32'(out_valid), 0);
      check("t1_tile_idx", 32'(tile_idx), 1);
      check("t1_cap_ready", 32'(capture_ready), 1);

      // Ready toggling 1-0-1-0: 512 cycles including the capture cycle
      pulse_start();
      check("t2_tile_idx", 32'(tile_idx), 0);
      capture(mk(0, 0), 0);
      wait_drain("t2", 1'b1, cyc);
      check("t2_cycles", cyc + 1, 512);

      // Four tiles to completion
      pulse_start();
      for (int t = 0; t < NUM_TILES; t++) begin
         capture(mk(1, t), t);
         wait_drain("t3", 1'b0, cyc);
      end
      check("t3_all_done", 32'(all_done), 1);
      check("t3_cap_ready", 32'(capture_ready), 0);
      check("t3_valid", 32'(out_valid), 0);
      check("t3_tile_idx", 32'(tile_idx), NUM_TILES - 1);
      OFM = mk(3, 0);
      ofm_capture = 1'b1;
      tick();
      ofm_capture = 1'b0;
      check("t3_done_overflow", 32'(overflow), 1);
      check("t3_done_stays", 32'(all_done), 1);
      pulse_start();
      check("t3_start_all_done", 32'(all_done), 0);
      check("t3_start_overflow", 32'(overflow), 0);
      check("t3_start_tile_idx", 32'(tile_idx), 0);

      // Capture on the final handshake of tile 0
      capture(mk(2, 0), 0);
      n = 0;
      while (!out_last && n < 600) begin
         tick();
         n++;
      end
      check("t4_reach_last", 32'(out_last), 1);
      check("t4_cap_ready", 32'(capture_ready), 1);
      capture(mk(3, 1), 1);
      check("t4_valid", 32'(out_valid), 1);
      check("t4_addr", 32'(out_addr), 256);
      check("t4_data", 32'(out_data), 32'hFF);
      check("t4_overflow", 32'(overflow), 0);
      check("t4_tile_idx", 32'(tile_idx), 1);
      wait_drain("t4", 1'b0, cyc);
      check("t4_tile_idx_end", 32'(tile_idx), 2);

      // Capture mid-drain is dropped and flags overflow
      pulse_start();
      capture(mk(0, 0), 0);
      wait_addr("t5_reach_100", 100);
      check("t5_cap_ready", 32'(capture_ready), 0);
      OFM = mk(3, 0);
      ofm_capture = 1'b1;
      tick();
      ofm_capture = 1'b0;
      check("t5_overflow", 32'(overflow), 1);
      wait_drain("t5", 1'b0, cyc);
      check("t5_overflow_sticky", 32'(overflow), 1);
      check("t5_tile_idx", 32'(tile_idx), 1);
      pulse_start();
      check("t5_clr_overflow", 32'(overflow), 0);
      check("t5_clr_tile_idx", 32'(tile_idx), 0);
      check("t5_clr_all_done", 32'(all_done), 0);
      check("t5_clr_valid", 32'(out_valid), 0);

      // Asynchronous reset mid-drain
      capture(mk(2, 0), 0);
      wait_addr("t6_reach_50", 50);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_async_valid", 32'(out_valid), 0);
      check("t6_async_addr", 32'(out_addr), 0);
      sb.delete();
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      capture(mk(3, 0), 0);
      check("t6_restart_valid", 32'(out_valid), 1);
      check("t6_restart_addr", 32'(out_addr), 0);
      wait_drain("t6", 1'b0, cyc);
      check("t6_tile_idx", 32'(tile_idx), 1);

      tick();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/ofm_tile_drain.md
Name: ofm_tile_drain

Overview:
- Receiver end of the CONV_256PE output path.
- On a capture strobe, latches the full NUM_OF_PE-byte OFM vector from the PE array.
- Streams the latched vector out one byte per handshake, with a linear OFM address, to the output-feature-map memory writer.
- Counts tiles and flags completion of a full feature map; flags overrun when a new tile arrives before the previous one has drained.

Parameters:
- NUM_OF_PE, 256, number of PE lanes (bytes per OFM vector).
- DATA_W, 8, bits per OFM element.
- NUM_TILES, 4, tiles per output channel (x_size*x_size / NUM_OF_PE; 1024/256).
- ADDR_W, $clog2(NUM_OF_PE*NUM_TILES), output address width (10 at defaults).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; clears tile counter, overflow and done; valid in any state.
- OFM  in  NUM_OF_PE*DATA_W  PE array output; lane m = OFM[m*DATA_W +: DATA_W].
- ofm_capture  in  1  single-cycle strobe; OFM is valid this cycle (tile finished).
- capture_ready  out  1  high when a capture this cycle will be accepted.
- out_data  out  DATA_W  current output byte.
- out_addr  out  ADDR_W  tile_idx*NUM_OF_PE + byte_idx.
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  downstream accepts the byte when out_valid && out_ready.
- out_last  out  1  high with the last byte (byte_idx == NUM_OF_PE-1) of each tile.
- tile_idx  out  $clog2(NUM_TILES)  index of the tile being, or next to be, drained.
- overflow  out  1  sticky; a capture was dropped.
- all_done  out  1  NUM_TILES tiles fully drained.

Behaviour:
- Reset (async assert, sync release): state=IDLE, capture buffer=0, byte_idx=0, tile_idx=0; out_valid, out_last, overflow and all_done are 0; out_data=0; out_addr=0.
- States: IDLE, DRAIN, DONE.
- IDLE:
  - capture_ready=1, out_valid=0.
  - ofm_capture=1: latch OFM, byte_idx<=0, go to DRAIN.
- DRAIN:
  - out_valid=1, out_data=buffer lane byte_idx, out_last=(byte_idx==NUM_OF_PE-1).
  - Handshake with byte_idx<NUM_OF_PE-1: byte_idx++.
  - Handshake on the last byte, tile_idx<NUM_TILES-1: tile_idx++, byte_idx<=0, go to IDLE.
  - Handshake on the last byte, tile_idx==NUM_TILES-1: go to DONE.
  - No handshake: out_data, out_addr and out_last hold stable while out_valid=1 (AXI-stream rules; valid is never withdrawn).
- DONE: all_done=1, out_valid=0, capture_ready=0.
- capture_ready = (state==IDLE) || (state==DRAIN && out_last && out_ready && tile_idx<NUM_TILES-1).
- Capture accepted in the same cycle as the final handshake of a non-final tile: latch the new OFM, byte_idx<=0, tile_idx++, stay in DRAIN. There is no idle bubble, so the next byte comes out on the next cycle.
- Capture with capture_ready=0 (mid-drain or DONE): data dropped, overflow<=1 (sticky until start or reset), state unaffected.
- Latency: capture in cycle N -> out_valid=1 with lane 0 in cycle N+1. Throughput is 1 byte/cycle with out_ready held high, so a tile takes NUM_OF_PE cycles.
- start:
  - Forces state=IDLE, tile_idx=0, byte_idx=0, overflow=0, all_done=0; the buffer is not cleared.
  - start has priority over ofm_capture in the same cycle; that capture is dropped without setting overflow.
- Reset mid-drain: drain aborts and all state returns to reset values; there is no partial-tile resume.
- Byte order: lane 0 first. out_addr is monotonically increasing across tiles, 0 .. NUM_OF_PE*NUM_TILES-1.

Decomposition:
- Package conv_pkg holds NUM_OF_PE, DATA_W, NUM_TILES and the drain state enum (IDLE, DRAIN, DONE), shared with the future PE-array feeder.
- No sub-module. The buffer is a NUM_OF_PE*DATA_W register with an indexed byte select; a shift-right-by-DATA_W implementation is equivalent and allowed.

Test Plan:
- Reset, then capture OFM with lane m = m (8'h00..8'hFF), out_ready=1 -> out_valid from the next cycle; 256 bytes 00..FF at addr 0..255; out_last only on byte FF; returns to IDLE, tile_idx=1.
- Same tile with out_ready toggling 1-0-1-0 -> every byte delivered exactly once, in order; out_data/out_addr stable during ready-low cycles; 512 cycles total.
- Four tiles, lanes = tile*16 + (m%16) -> addresses 0..1023 contiguous; all_done=1 after handshake 1024; capture_ready=0 in DONE.
- Second capture pulsed in the same cycle as tile 0's last handshake -> accepted; byte 0 of tile 1 at addr 256 next cycle; overflow stays 0.
- Capture pulsed at byte 100 of a drain -> overflow=1; current tile finishes unchanged; start then clears overflow, tile_idx and all_done to 0.
- reset_n dropped asynchronously at byte 50 -> out_valid=0 immediately, no clock edge required; after release, a capture restarts from addr 0.
